bp_me_wb_arbiter: RTL and testbench
===================================

Name: bp_me_wb_arbiter

Overview:
- Round-robin arbiter that shares one 64-bit Wishbone client port (the WB-to-BedRock adapter) between num_masters_p Wishbone masters.
- Grants the bus per Wishbone cycle: the grant is locked while the granted master holds cyc.
- Routes stb/adr/dat/sel/we/cti/bte downstream and ack/err/rty upstream.
- Sits between on-chip WB masters (debug module, DMA, accelerator) and the bridge into the BP memory bus.

Parameters:
- num_masters_p, 2, number of upstream WB masters (≥2).
- paddr_width_p, from bp_params_p, physical address width.
- wbone_addr_width_lp, paddr_width_p-3, WB word address width (64-bit words).
- wbone_data_width_lp, 64, WB data width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- m_adr_i  in  num_masters_p*wbone_addr_width_lp  per-master word address, master i at slice i.
- m_dat_i  in  num_masters_p*64  per-master write data.
- m_sel_i  in  num_masters_p*8  per-master byte select.
- m_we_i, m_stb_i, m_cyc_i  in  num_masters_p  per-master controls.
- m_cti_i  in  num_masters_p*3  per-master cycle type.
- m_bte_i  in  num_masters_p*2  per-master burst type.
- m_dat_o  out  64  read data, broadcast to all masters.
- m_ack_o, m_err_o, m_rty_o  out  num_masters_p  per-master termination.
- s_adr_o  out  wbone_addr_width_lp  downstream word address.
- s_dat_o  out  64  downstream write data.
- s_sel_o  out  8  downstream byte select.
- s_we_o, s_stb_o, s_cyc_o  out  1  downstream controls.
- s_cti_o  out  3  downstream cycle type.
- s_bte_o  out  2  downstream burst type.
- s_dat_i  in  64  downstream read data.
- s_ack_i, s_err_i, s_rty_i  in  1  downstream termination.
- grant_o  out  num_masters_p  one-hot current owner; all-zero when idle.

Behaviour:
- Reset: asynchronous and active-high; takes effect without waiting for a clock edge.
  - State forced to IDLE; grant register = 0; round-robin pointer = 0.
  - Every s_* output is 0, every m_ack/err/rty is 0, grant_o = 0.
- State IDLE:
  - Downstream outputs all 0.
  - Request vector = m_cyc_i. If any bit is set, pick the first set bit at or after the pointer, wrapping modulo num_masters_p.
  - Next edge: load the winner's one-hot into grant_reg and move to BUSY.
  - Arbitration latency: 1 cycle from cyc_i to s_cyc_o.
- State BUSY (mux is combinational from grant_reg):
  - s_cyc_o = m_cyc_i[g]; s_stb_o = m_stb_i[g] & m_cyc_i[g]; adr/dat/sel/we/cti/bte come from slice g.
  - m_ack_o[g] = s_ack_i, m_err_o[g] = s_err_i, m_rty_o[g] = s_rty_i; all other masters' termination bits = 0.
  - m_dat_o = s_dat_i at all times, regardless of state.
  - Requests from other masters are ignored while BUSY; no preemption.
- Release:
  - When m_cyc_i[g] = 0 in BUSY, s_cyc_o drops in the same cycle.
  - Next edge: state → IDLE, pointer = (g+1) mod num_masters_p, grant_reg = 0.
  - Exactly one IDLE turnaround cycle follows every WB cycle, so back-to-back owners are separated by ≥1 cycle with s_cyc_o = 0.
- Multi-transfer cycles:
  - The master keeps cyc high across several stb/ack pairs (classic or registered burst); grant is held throughout.
  - cti/bte pass through unmodified.
- Simultaneous requests: with the pointer at p, master p wins if requesting. Two masters requesting continuously alternate grants (fairness).
- Same-master re-request: after release the pointer has advanced, so another waiting master wins first. If none waits, the same master is re-granted after the IDLE cycle.
- Protocol violation: the granted master drops cyc with a termination still outstanding. Any late s_ack_i/err/rty arriving in IDLE is discarded, i.e. not routed to any master.
- Reset mid-cycle: immediate release. The downstream sees cyc fall asynchronously; no termination is delivered upstream.
- Pointer arithmetic: width $clog2(num_masters_p); wraps at num_masters_p-1 → 0, including non-power-of-2 counts.

Decomposition:
- bp_me_wb_pkg holds:
  - wbone_data_width, sel width (8), cti/bte widths;
  - cti encodings (classic 3'b000, incrementing 3'b010, end 3'b111);
  - macro for the WB address width from paddr_width_p.
- State enum {IDLE, BUSY} stays local to the module.
- Sub-module: bp_me_wb_rr_arb, a combinational round-robin picker (req vector + pointer → one-hot winner + encoded index). The FSM, pointer, grant register and muxes stay in bp_me_wb_arbiter.

Test Plan:
- Single master: after reset, m_cyc_i=01, stb, adr=0x1000, we=0.
  - Required: grant_o=01 one cycle later.
  - s_adr_o=0x1000 with s_stb_o=1; s_ack_i with s_dat_i=0xDEADBEEF_CAFEF00D → m_ack_o=01, m_dat_o=0xDEADBEEF_CAFEF00D.
  - m_ack_o[1] stays 0 throughout.
- Both masters request continuously, 4 single-transfer cycles each.
  - Required: grant sequence 01,10,01,10…; one IDLE cycle (s_cyc_o=0) between owners; each master receives exactly 4 acks.
- Master 0 holds a 4-beat burst (cti=010…111) while master 1 requests from its second beat.
  - Required: master 1 is not granted until cyc0 falls; all 4 acks go to master 0 only.
- num_masters_p=3, pointer at 2, requests 011.
  - Required: master 0 wins (wrap). Next grant is master 1, then master 0.
- Assert reset_i mid-BUSY between edges.
  - Required: s_cyc_o, s_stb_o and grant_o go to 0 before the next clock edge.
  - After release, pointer = 0 and a fresh request is granted in 1 cycle.
- Granted master drops cyc, then s_ack_i pulses one cycle late.
  - Required: all m_ack_o bits stay 0; next arbitration proceeds normally.

Source files
------------

// File: rtl/bp_me_wb_pkg.sv
// Shared Wishbone constants for the BP memory-engine Wishbone blocks.
// The address-width macro maps a BP physical address width onto a
// 64-bit-word Wishbone address width.

`define BP_ME_WB_ADDR_WIDTH(paddr_mp) ((paddr_mp) - 3)

package bp_me_wb_pkg;

    localparam int wbone_data_width_gp = 64;
    localparam int wbone_sel_width_gp  = wbone_data_width_gp / 8;
    localparam int wbone_cti_width_gp  = 3;
    localparam int wbone_bte_width_gp  = 2;

    // Cycle type identifiers that the arbiter passes through untouched
    typedef enum logic [wbone_cti_width_gp-1:0] {
        e_wb_cti_classic = 3'b000,
        e_wb_cti_incr    = 3'b010,
        e_wb_cti_end     = 3'b111
    } bp_me_wb_cti_e;

endpackage

// File: rtl/bp_me_wb_rr_arb.sv
// Combinational round-robin picker: returns the first requester at or
// after ptr_i, wrapping modulo num_masters_p, as one-hot and as an index.

module bp_me_wb_rr_arb #(
    parameter int num_masters_p = 2,
    localparam int ptr_width_lp = $clog2(num_masters_p)
) (
    input  logic [num_masters_p-1:0] req_i,
    input  logic [ptr_width_lp-1:0]  ptr_i,
    output logic [num_masters_p-1:0] grant_o,
    output logic [ptr_width_lp-1:0]  idx_o,
    output logic                     v_o
);

    logic [ptr_width_lp-1:0] cand_idx;

    // Scan offsets from farthest to nearest so the nearest requester is the last write
    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        v_o      = 1'b0;
        cand_idx = '0;
        for (int k = num_masters_p - 1; k >= 0; k--) begin
            cand_idx = ptr_width_lp'((int'(ptr_i) + k) % num_masters_p);
            if (req_i[cand_idx]) begin
                v_o               = 1'b1;
                idx_o             = cand_idx;
                grant_o           = '0;
                grant_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_me_wb_arbiter.sv
// Round-robin arbiter sharing one 64-bit Wishbone client port between
// several Wishbone masters. Ownership is taken per Wishbone cycle and held
// while the owner keeps cyc high; every release costs one IDLE cycle.

module bp_me_wb_arbiter
    import bp_me_wb_pkg::*;
#(
    parameter int num_masters_p = 2,
    parameter int paddr_width_p = 40,
    localparam int wbone_addr_width_lp = `BP_ME_WB_ADDR_WIDTH(paddr_width_p),
    localparam int wbone_data_width_lp = wbone_data_width_gp,
    localparam int sel_width_lp        = wbone_sel_width_gp,
    localparam int cti_width_lp        = wbone_cti_width_gp,
    localparam int bte_width_lp        = wbone_bte_width_gp,
    localparam int ptr_width_lp        = $clog2(num_masters_p)
) (
    input  logic                                         clk_i,
    input  logic                                         reset_i,

    input  logic [num_masters_p*wbone_addr_width_lp-1:0] m_adr_i,
    input  logic [num_masters_p*wbone_data_width_lp-1:0] m_dat_i,
    input  logic [num_masters_p*sel_width_lp-1:0]        m_sel_i,
    input  logic [num_masters_p-1:0]                     m_we_i,
    input  logic [num_masters_p-1:0]                     m_stb_i,
    input  logic [num_masters_p-1:0]                     m_cyc_i,
    input  logic [num_masters_p*cti_width_lp-1:0]        m_cti_i,
    input  logic [num_masters_p*bte_width_lp-1:0]        m_bte_i,
    output logic [wbone_data_width_lp-1:0]               m_dat_o,
    output logic [num_masters_p-1:0]                     m_ack_o,
    output logic [num_masters_p-1:0]                     m_err_o,
    output logic [num_masters_p-1:0]                     m_rty_o,

    output logic [wbone_addr_width_lp-1:0]               s_adr_o,
    output logic [wbone_data_width_lp-1:0]               s_dat_o,
    output logic [sel_width_lp-1:0]                      s_sel_o,
    output logic                                         s_we_o,
    output logic                                         s_stb_o,
    output logic                                         s_cyc_o,
    output logic [cti_width_lp-1:0]                      s_cti_o,
    output logic [bte_width_lp-1:0]                      s_bte_o,
    input  logic [wbone_data_width_lp-1:0]               s_dat_i,
    input  logic                                         s_ack_i,
    input  logic                                         s_err_i,
    input  logic                                         s_rty_i,

    output logic [num_masters_p-1:0]                     grant_o
);

    typedef enum logic {e_idle, e_busy} state_e;

    state_e                     state_reg;
    logic [num_masters_p-1:0]   grant_reg;
    logic [ptr_width_lp-1:0]    grant_idx_reg;
    logic [ptr_width_lp-1:0]    ptr_reg;

    logic [num_masters_p-1:0]   arb_grant;
    logic [ptr_width_lp-1:0]    arb_idx;
    logic                       arb_v;
    logic                       busy;

    // Per-master views of the packed input buses
    logic [wbone_addr_width_lp-1:0] adr_arr [num_masters_p];
    logic [wbone_data_width_lp-1:0] dat_arr [num_masters_p];
    logic [sel_width_lp-1:0]        sel_arr [num_masters_p];
    logic [cti_width_lp-1:0]        cti_arr [num_masters_p];
    logic [bte_width_lp-1:0]        bte_arr [num_masters_p];

    assign busy = (state_reg == e_busy);

    bp_me_wb_rr_arb #(
        .num_masters_p(num_masters_p)
    ) rr_arb (
        .req_i  (m_cyc_i),
        .ptr_i  (ptr_reg),
        .grant_o(arb_grant),
        .idx_o  (arb_idx),
        .v_o    (arb_v)
    );

    for (genvar gi = 0; gi < num_masters_p; gi++) begin : g_master
        assign adr_arr[gi] = m_adr_i[gi*wbone_addr_width_lp +: wbone_addr_width_lp];
        assign dat_arr[gi] = m_dat_i[gi*wbone_data_width_lp +: wbone_data_width_lp];
        assign sel_arr[gi] = m_sel_i[gi*sel_width_lp +: sel_width_lp];
        assign cti_arr[gi] = m_cti_i[gi*cti_width_lp +: cti_width_lp];
        assign bte_arr[gi] = m_bte_i[gi*bte_width_lp +: bte_width_lp];

        // Terminations reach only the owner; anything arriving in IDLE is dropped
        assign m_ack_o[gi] = busy & grant_reg[gi] & s_ack_i;
        assign m_err_o[gi] = busy & grant_reg[gi] & s_err_i;
        assign m_rty_o[gi] = busy & grant_reg[gi] & s_rty_i;
    end

    assign m_dat_o = s_dat_i;
    assign grant_o = grant_reg;

    // Downstream mux driven from the registered owner; quiet while IDLE
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        if (busy) begin
            s_adr_o = adr_arr[grant_idx_reg];
            s_dat_o = dat_arr[grant_idx_reg];
            s_sel_o = sel_arr[grant_idx_reg];
            s_we_o  = m_we_i[grant_idx_reg];
            s_cyc_o = m_cyc_i[grant_idx_reg];
            s_stb_o = m_stb_i[grant_idx_reg] & m_cyc_i[grant_idx_reg];
            s_cti_o = cti_arr[grant_idx_reg];
            s_bte_o = bte_arr[grant_idx_reg];
        end
    end

    // Ownership FSM: arbitrate in IDLE, hold until the owner drops cyc, then advance the pointer
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg     <= e_idle;
            grant_reg     <= '0;
            grant_idx_reg <= '0;
            ptr_reg       <= '0;
        end else begin
            case (state_reg)
                e_idle: begin
                    if (arb_v) begin
                        state_reg     <= e_busy;
                        grant_reg     <= arb_grant;
                        grant_idx_reg <= arb_idx;
                    end
                end
                e_busy: begin
                    if (!m_cyc_i[grant_idx_reg]) begin
                        state_reg <= e_idle;
                        grant_reg <= '0;
                        ptr_reg   <= (grant_idx_reg == ptr_width_lp'(num_masters_p - 1))
                                     ? '0 : grant_idx_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= e_idle;
                    grant_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bp_me_wb_arbiter.sv
// Directed testbench for bp_me_wb_arbiter: a two-master instance for most
// scenarios and a three-master instance for pointer wrap-around.

module tb_bp_me_wb_arbiter;

    localparam int AW = 37;

    logic clk_i = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Two-master instance
    logic [2*AW-1:0] m_adr;
    logic [127:0]    m_dat;
    logic [15:0]     m_sel;
    logic [1:0]      m_we, m_stb, m_cyc;
    logic [5:0]      m_cti;
    logic [3:0]      m_bte;
    logic [63:0]     m_dat_o;
    logic [1:0]      m_ack_o, m_err_o, m_rty_o, grant_o;
    logic [AW-1:0]   s_adr_o;
    logic [63:0]     s_dat_o;
    logic [7:0]      s_sel_o;
    logic            s_we_o, s_stb_o, s_cyc_o;
    logic [2:0]      s_cti_o;
    logic [1:0]      s_bte_o;

    // Shared downstream stimulus
    logic [63:0]     s_dat;
    logic            s_ack, s_err, s_rty;

    // Three-master instance
    logic [3*AW-1:0] t_adr;
    logic [191:0]    t_dat;
    logic [23:0]     t_sel;
    logic [2:0]      t_we, t_stb, t_cyc;
    logic [8:0]      t_cti;
    logic [5:0]      t_bte;
    logic [63:0]     t_dat_o;
    logic [2:0]      t_ack_o, t_err_o, t_rty_o, t_grant_o;
    logic [AW-1:0]   t_s_adr_o;
    logic [63:0]     t_s_dat_o;
    logic [7:0]      t_s_sel_o;
    logic            t_s_we_o, t_s_stb_o, t_s_cyc_o;
    logic [2:0]      t_s_cti_o;
    logic [1:0]      t_s_bte_o;

    bp_me_wb_arbiter #(.num_masters_p(2), .paddr_width_p(40)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_stb_i(m_stb), .m_cyc_i(m_cyc), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(grant_o)
    );

    bp_me_wb_arbiter #(.num_masters_p(3), .paddr_width_p(40)) dut3 (
        .clk_i(clk_i), .reset_i(reset_i),
        .m_adr_i(t_adr), .m_dat_i(t_dat), .m_sel_i(t_sel), .m_we_i(t_we),
        .m_stb_i(t_stb), .m_cyc_i(t_cyc), .m_cti_i(t_cti), .m_bte_i(t_bte),
        .m_dat_o(t_dat_o), .m_ack_o(t_ack_o), .m_err_o(t_err_o), .m_rty_o(t_rty_o),
        .s_adr_o(t_s_adr_o), .s_dat_o(t_s_dat_o), .s_sel_o(t_s_sel_o), .s_we_o(t_s_we_o),
        .s_stb_o(t_s_stb_o), .s_cyc_o(t_s_cyc_o), .s_cti_o(t_s_cti_o), .s_bte_o(t_s_bte_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(t_grant_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_stb = '0; m_cyc = '0;
        m_cti = '0; m_bte = '0;
        t_adr = '0; t_dat = '0; t_sel = '0; t_we = '0; t_stb = '0; t_cyc = '0;
        t_cti = '0; t_bte = '0;
        s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
        reset_i = 1'b1;
        #2;
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: got cyc/stb/we=%b, want 000", {s_cyc_o, s_stb_o, s_we_o});
        end
        checks++;
        if (grant_o !== 2'b00 || m_ack_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_grant: got grant=%b ack=%b, want 00/00", grant_o, m_ack_o);
        end
        checks++;
        if (s_adr_o !== '0 || s_sel_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus: got adr=%h sel=%h, want 0/0", s_adr_o, s_sel_o);
        end
        $display("reset: grant=%b s_cyc=%b", grant_o, s_cyc_o);
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b00;
        m_adr[0 +: AW] = 37'h1000; m_adr[AW +: AW] = 37'h2000;
        m_dat[63:0] = 64'h0123_4567_89AB_CDEF; m_dat[127:64] = 64'h1111_2222_3333_4444;
        m_sel[7:0] = 8'hF0; m_sel[15:8] = 8'h0F;
        #1;
        checks++;
        if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got grant=%b s_cyc=%b, want 00/0", grant_o, s_cyc_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b01) begin
            errors++;
            $display("FAIL single_grant: got %b, want 01", grant_o);
        end
        checks++;
        if (s_stb_o !== 1'b1 || s_adr_o !== 37'h1000 || s_we_o !== 1'b0) begin
            errors++;
            $display("FAIL single_req: got stb=%b adr=%h we=%b, want 1/1000/0", s_stb_o, s_adr_o, s_we_o);
        end
        checks++;
        if (s_dat_o !== 64'h0123_4567_89AB_CDEF || s_sel_o !== 8'hF0) begin
            errors++;
            $display("FAIL single_wdata: got dat=%h sel=%h, want 0123456789abcdef/f0", s_dat_o, s_sel_o);
        end
        s_ack = 1'b1; s_dat = 64'hDEADBEEF_CAFEF00D;
        #1;
        checks++;
        if (m_ack_o !== 2'b01 || m_dat_o !== 64'hDEADBEEF_CAFEF00D) begin
            errors++;
            $display("FAIL single_ack: got ack=%b dat=%h, want 01/deadbeefcafef00d", m_ack_o, m_dat_o);
        end
        tick();
        s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
        #1;
        checks++;
        if (s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got s_cyc=%b, want 0", s_cyc_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("FAIL single_idle: got grant=%b, want 00", grant_o);
        end
        $display("single: master 0 read adr=1000 data=%h", m_dat_o);
    endtask

    task automatic test_back_to_back();
        int owner;
        int acks0;
        int acks1;
        logic [1:0] want;
        owner = 0; acks0 = 0; acks1 = 0;
        do_reset();
        m_cyc = 2'b11; m_stb = 2'b11;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (s_cyc_o !== 1'b0) begin
                errors++;
                $display("FAIL b2b_gap[%0d]: got s_cyc=%b, want 0", i, s_cyc_o);
            end
            tick();
            want = (owner == 0) ? 2'b01 : 2'b10;
            checks++;
            if (grant_o !== want) begin
                errors++;
                $display("FAIL b2b_grant[%0d]: got %b, want %b", i, grant_o, want);
            end
            s_ack = 1'b1;
            #1;
            acks0 += int'(m_ack_o[0]);
            acks1 += int'(m_ack_o[1]);
            $display("b2b txn %0d: grant=%b ack=%b", i, grant_o, m_ack_o);
            tick();
            s_ack = 1'b0;
            m_cyc[owner] = 1'b0; m_stb[owner] = 1'b0;
            tick();
            m_cyc[owner] = 1'b1; m_stb[owner] = 1'b1;
            owner = 1 - owner;
        end
        checks++;
        if (acks0 != 4 || acks1 != 4) begin
            errors++;
            $display("FAIL b2b_acks: got m0=%0d m1=%0d, want 4/4", acks0, acks1);
        end
        m_cyc = 2'b00; m_stb = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_burst();
        logic [2:0] cti;
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01; m_bte[1:0] = 2'b01; m_cti[2:0] = 3'b010;
        m_cti[5:3] = 3'b111; m_bte[3:2] = 2'b11;
        tick();
        for (int b = 0; b < 4; b++) begin
            if (b >= 1) begin
                m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
            end
            cti = (b == 3) ? 3'b111 : 3'b010;
            m_cti[2:0] = cti;
            s_ack = 1'b1;
            #1;
            checks++;
            if (m_ack_o !== 2'b01 || grant_o !== 2'b01) begin
                errors++;
                $display("FAIL burst_beat[%0d]: got ack=%b grant=%b, want 01/01", b, m_ack_o, grant_o);
            end
            checks++;
            if (s_cti_o !== cti || s_bte_o !== 2'b01) begin
                errors++;
                $display("FAIL burst_cti[%0d]: got cti=%b bte=%b, want %b/01", b, s_cti_o, s_bte_o, cti);
            end
            $display("burst beat %0d: cti=%b ack=%b", b, s_cti_o, m_ack_o);
            tick();
        end
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        #1;
        checks++;
        if (grant_o !== 2'b01 || s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL burst_hold: got grant=%b s_cyc=%b, want 01/0", grant_o, s_cyc_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("FAIL burst_idle: got %b, want 00", grant_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b10 || s_cti_o !== 3'b111) begin
            errors++;
            $display("FAIL burst_next: got grant=%b cti=%b, want 10/111", grant_o, s_cti_o);
        end
        m_cyc = 2'b00; m_stb = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_wrap3();
        do_reset();
        t_cyc = 3'b010;
        tick();
        checks++;
        if (t_grant_o !== 3'b010) begin
            errors++;
            $display("FAIL wrap_setup: got %b, want 010", t_grant_o);
        end
        t_cyc = 3'b000;
        tick();
        t_cyc = 3'b011;
        tick();
        checks++;
        if (t_grant_o !== 3'b001) begin
            errors++;
            $display("FAIL wrap_first: got %b, want 001", t_grant_o);
        end
        t_cyc = 3'b010;
        tick();
        t_cyc = 3'b011;
        tick();
        checks++;
        if (t_grant_o !== 3'b010) begin
            errors++;
            $display("FAIL wrap_second: got %b, want 010", t_grant_o);
        end
        t_cyc = 3'b001;
        tick();
        t_cyc = 3'b011;
        tick();
        checks++;
        if (t_grant_o !== 3'b001) begin
            errors++;
            $display("FAIL wrap_third: got %b, want 001", t_grant_o);
        end
        $display("wrap3: final grant=%b", t_grant_o);
        t_cyc = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01;
        tick();
        m_cyc = 2'b00; m_stb = 2'b00;
        tick();
        m_cyc = 2'b10; m_stb = 2'b10;
        tick();
        #1;
        checks++;
        if (s_cyc_o !== 1'b1 || grant_o !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_pre: got s_cyc=%b grant=%b, want 1/10", s_cyc_o, grant_o);
        end
        s_ack = 1'b1;
        #1;
        reset_i = 1'b1;
        #1;
        checks++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || grant_o !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_async: got cyc=%b stb=%b grant=%b, want 0/0/00", s_cyc_o, s_stb_o, grant_o);
        end
        checks++;
        if (m_ack_o !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_ack: got %b, want 00", m_ack_o);
        end
        #1;
        reset_i = 1'b0; s_ack = 1'b0;
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        checks++;
        if (grant_o !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_regrant: got %b, want 01", grant_o);
        end
        $display("reset_mid: regrant=%b", grant_o);
        m_cyc = 2'b00; m_stb = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_late_ack();
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01;
        tick();
        m_cyc = 2'b00; m_stb = 2'b00;
        tick();
        s_ack = 1'b1; m_cyc = 2'b10; m_stb = 2'b10;
        #1;
        checks++;
        if (m_ack_o !== 2'b00) begin
            errors++;
            $display("FAIL late_ack_drop: got %b, want 00", m_ack_o);
        end
        tick();
        s_ack = 1'b0;
        #1;
        checks++;
        if (grant_o !== 2'b10 || m_ack_o !== 2'b00) begin
            errors++;
            $display("FAIL late_next: got grant=%b ack=%b, want 10/00", grant_o, m_ack_o);
        end
        s_ack = 1'b1; s_rty = 1'b1;
        #1;
        checks++;
        if (m_ack_o !== 2'b10 || m_rty_o !== 2'b10 || m_err_o !== 2'b00) begin
            errors++;
            $display("FAIL late_term: got ack=%b rty=%b err=%b, want 10/10/00", m_ack_o, m_rty_o, m_err_o);
        end
        tick();
        s_ack = 1'b0; s_rty = 1'b0; s_err = 1'b1;
        #1;
        checks++;
        if (m_err_o !== 2'b10) begin
            errors++;
            $display("FAIL late_err: got %b, want 10", m_err_o);
        end
        $display("late_ack: grant=%b err=%b", grant_o, m_err_o);
        s_err = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_burst();
        test_wrap3();
        test_reset_mid();
        test_late_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
